loop_iter_seq: RTL and testbench

- Iteration sequencer that drives the event strobe consumed by a downstream `always @E` / `forever @E` worker stage.
- Implements do-while semantics in hardware: once started, it always issues one iteration.
- After each accepted iteration it samples a continue condition, bounded by a programmed maximum count.
- Sits between a command source (start/count) and the worker that consumes per-iteration strobes through a valid/ready handshake.

---
 rtl/loop_iter_seq.sv | 191 +++++++++++++++++++
 tb/tb_loop_iter_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_iter_seq.sv
// ---------------------------------------------------------------------------
// loop_iter_seq
//
// Iteration sequencer with do-while semantics. After a start it always issues
// at least one iteration strobe to a downstream worker over a valid/ready
// handshake. After each accepted iteration it samples a continue condition,
// and the loop is bounded by a maximum count that is latched at start.
//
// Optional feature (macro LOOP_ITER_SEQ_TIMEOUT_EN):
//   A stall watchdog counts ISSUE cycles without ready. When it reaches
//   TIMEOUT, the offered iteration is withdrawn. abort_o and done_o then pulse
//   together and the sequencer returns to IDLE. Without the macro, ISSUE waits
//   indefinitely and abort_o is tied to 0.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_i       in   start request, accepted only in IDLE
//   max_count_i   in   [CNT_W] maximum iteration count, 0 treated as 1
//   cond_i        in   continue condition, sampled in EVAL
//   iter_valid_o  out  iteration strobe offered to the worker
//   iter_ready_i  in   worker accepts the offered iteration
//   iter_idx_o    out  [CNT_W] index of the current iteration (from 0)
//   busy_o        out  high in every state except IDLE
//   done_o        out  one-cycle pulse when the loop ends
//   iter_total_o  out  [CNT_W] accepted iterations, held until next start
//   abort_o       out  one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module loop_iter_seq #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] max_count_i,
    input  logic             cond_i,
    output logic             iter_valid_o,
    input  logic             iter_ready_i,
    output logic [CNT_W-1:0] iter_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] iter_total_o,
    output logic             abort_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_total;

    logic             w_handshake;
    logic             w_timeout;
    logic [CNT_W:0]   w_idxPlusOne;
    logic             w_moreAllowed;

    assign w_handshake = (r_state == S_ISSUE) && iter_ready_i;

    // The next-index comparison uses one extra bit, so idx+1 cannot wrap
    // back below the latched count when the count is at its maximum value.
    assign w_idxPlusOne  = {1'b0, r_idx} + {{CNT_W{1'b0}}, 1'b1};
    assign w_moreAllowed = (w_idxPlusOne < {1'b0, r_count});

`ifdef LOOP_ITER_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_abort;

    // The stall count is zero whenever we are outside ISSUE or a handshake
    // happens, so it starts from zero on every entry to ISSUE. The abort
    // decision is made on the cycle that would bring the count to TIMEOUT,
    // which means the strobe is withdrawn on the following cycle.
    assign w_timeout = (r_state == S_ISSUE) && !iter_ready_i &&
                       (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            if ((r_state != S_ISSUE) || iter_ready_i) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + STALL_W'(1);
            end

            if (w_timeout) begin
                r_abort <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_abort <= 1'b0;
            end
        end
    end

    assign abort_o = r_abort && (r_state == S_DONE);
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic w_unusedTimeout;
    assign w_unusedTimeout = ^TIMEOUT;

    assign w_timeout = 1'b0;
    assign abort_o   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_nextState  = r_state;
        iter_valid_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                iter_valid_o = 1'b1;
                if (iter_ready_i) begin
                    w_nextState = S_EVAL;
                end else if (w_timeout) begin
                    w_nextState = S_DONE;
                end
            end
            S_EVAL: begin
                if (cond_i && w_moreAllowed) begin
                    w_nextState = S_ISSUE;
                end else begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Loop bookkeeping: latched bound, current index and accepted total.
    // The total can never exceed the latched count, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_idx   <= '0;
            r_total <= '0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_count <= (max_count_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                               : max_count_i;
                r_idx   <= '0;
                r_total <= '0;
            end

            if (w_handshake) begin
                r_total <= r_total + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if ((r_state == S_EVAL) && cond_i && w_moreAllowed) begin
                r_idx <= r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign iter_idx_o   = r_idx;
    assign iter_total_o = r_total;

endmodule

// File: tb/tb_loop_iter_seq.sv
// ---------------------------------------------------------------------------
// tb_loop_iter_seq
//
// Self-checking bench for loop_iter_seq. Each run pushes the expected
// iteration indices, handshake cycles, done cycle, total and abort flag into
// queues when the start is driven. A negedge monitor pops and compares them
// when the sequencer produces handshakes and done pulses.
// With LOOP_ITER_SEQ_TIMEOUT_EN defined, the DUT is built with TIMEOUT=4 and
// a watchdog abort run is added.
// ---------------------------------------------------------------------------
module tb_loop_iter_seq;

    localparam int CNT_W = 8;
`ifdef LOOP_ITER_SEQ_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 64;
`endif
    localparam int STALL_LEN = (TIMEOUT > 5) ? 5 : TIMEOUT - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] max_count_i;
    logic             cond_i;
    logic             iter_valid_o;
    logic             iter_ready_i;
    logic [CNT_W-1:0] iter_idx_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] iter_total_o;
    logic             abort_o;

    int checks = 0;
    int errors = 0;
    int cycleNum = 0;
    int hsCount = 0;
    bit doneSeen = 1'b0;

    int idxQ[$];
    int hsCycQ[$];
    int doneQ[$];
    int totalQ[$];
    int abortQ[$];

    loop_iter_seq #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .max_count_i  (max_count_i),
        .cond_i       (cond_i),
        .iter_valid_o (iter_valid_o),
        .iter_ready_i (iter_ready_i),
        .iter_idx_o   (iter_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .iter_total_o (iter_total_o),
        .abort_o      (abort_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
                     tag, observed, expected, cycleNum);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (iter_valid_o) begin
                if (idxQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(idxQ.size()), 1);
                end else begin
                    checkOutput("iterIdx", 32'(iter_idx_o), idxQ[0]);
                end
                if (iter_ready_i) begin
                    hsCount++;
                    checkOutput("busyInIssue", 32'(busy_o), 1);
                    if (hsCycQ.size() == 0) begin
                        checkOutput("unexpectedHandshake", 32'(hsCycQ.size()), 1);
                    end else begin
                        checkOutput("hsCycle", cycleNum, hsCycQ.pop_front());
                    end
                    if (idxQ.size() > 0) void'(idxQ.pop_front());
                end
            end
            if (abort_o && !done_o) begin
                checkOutput("abortWithoutDone", 32'(done_o), 1);
            end
            if (done_o) begin
                doneSeen = 1'b1;
                if (doneQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(doneQ.size()), 1);
                end else begin
                    checkOutput("doneCycle", cycleNum, doneQ.pop_front());
                    checkOutput("iterTotal", 32'(iter_total_o), totalQ.pop_front());
                    checkOutput("abortFlag", 32'(abort_o), abortQ.pop_front());
                    checkOutput("missingIters", 32'(idxQ.size()), 0);
                    checkOutput("busyInDone", 32'(busy_o), 1);
                    checkOutput("validInDone", 32'(iter_valid_o), 0);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(iter_valid_o), 0);
        checkOutput({tag, "_busy"},  32'(busy_o), 0);
        checkOutput({tag, "_done"},  32'(done_o), 0);
        checkOutput({tag, "_abort"}, 32'(abort_o), 0);
        checkOutput({tag, "_idx"},   32'(iter_idx_o), 0);
        checkOutput({tag, "_total"}, 32'(iter_total_o), 0);
    endtask

    // One loop run. stopAfter drops cond_i at the EVAL following that many
    // handshakes (-1 never). stall holds ready low for that many ISSUE cycles
    // of the first iteration. pokeDone pulses start_i during the DONE cycle.
    task automatic applyStimulus(input int maxCount, input int stopAfter,
                                 input int stall, input bit pokeDone);
        int k;
        int n;
        int expDone;
        int budget;
        n = (maxCount == 0) ? 1 : maxCount;
        if (stopAfter > 0 && stopAfter < n) n = stopAfter;
        @(posedge clk); #1;
        k = cycleNum;
        hsCount = 0;
        doneSeen = 1'b0;
        for (int i = 0; i < n; i++) begin
            idxQ.push_back(i);
            hsCycQ.push_back(k + 1 + stall + 2 * i);
        end
        expDone = k + 1 + stall + 2 * n;
        doneQ.push_back(expDone);
        totalQ.push_back(n);
        abortQ.push_back(0);
        start_i      = 1'b1;
        max_count_i  = CNT_W'(maxCount);
        iter_ready_i = (stall == 0);
        cond_i       = 1'b1;
        budget = 0;
        while (!doneSeen && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
            start_i      = pokeDone && (cycleNum == expDone);
            if (cycleNum == k + 1) max_count_i = CNT_W'($urandom_range(0, 255));
            iter_ready_i = (cycleNum >= k + 1 + stall);
            cond_i       = (hsCount != stopAfter);
        end
        start_i = 1'b0;
        if (!doneSeen) checkOutput("doneTimeout", 32'(doneSeen), 1);
        if (pokeDone) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("startInDoneIgnored", 32'(busy_o), 0);
            end
        end
    endtask

    initial begin
        int k;
        rst          = 1'b1;
        start_i      = 1'b0;
        max_count_i  = '0;
        cond_i       = 1'b0;
        iter_ready_i = 1'b0;
        #2;
        checkAllZero("resetState");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single iteration");
        applyStimulus(1, -1, 0, 1'b1);

        $display("[TB] count bound of 4");
        applyStimulus(4, -1, 0, 1'b0);

        $display("[TB] early exit after 2");
        applyStimulus(10, 2, 0, 1'b0);

        $display("[TB] zero count with backpressure");
        applyStimulus(0, -1, STALL_LEN, 1'b0);

        $display("[TB] reset mid-loop");
        @(posedge clk); #1;
        k = cycleNum;
        hsCount = 0;
        idxQ.push_back(0); hsCycQ.push_back(k + 1);
        idxQ.push_back(1); hsCycQ.push_back(k + 3);
        start_i      = 1'b1;
        max_count_i  = 8'd8;
        iter_ready_i = 1'b1;
        cond_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cycleNum < k + 5) begin
            @(posedge clk); #1;
        end
        checkOutput("thirdIssueIdx", 32'(iter_idx_o), 2);
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        checkOutput("itersBeforeReset", 32'(idxQ.size()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(2, -1, 0, 1'b0);

        $display("[TB] full-width count");
        applyStimulus(255, -1, 0, 1'b0);

`ifdef LOOP_ITER_SEQ_TIMEOUT_EN
        $display("[TB] watchdog abort");
        @(posedge clk); #1;
        k = cycleNum;
        doneSeen = 1'b0;
        idxQ.push_back(0);
        doneQ.push_back(k + 1 + TIMEOUT);
        totalQ.push_back(0);
        abortQ.push_back(1);
        start_i      = 1'b1;
        max_count_i  = 8'd1;
        iter_ready_i = 1'b0;
        cond_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 50 && !doneSeen; i++) begin
            @(posedge clk); #1;
        end
        if (!doneSeen) checkOutput("abortTimeout", 32'(doneSeen), 1);
        checkOutput("abortedIterPending", 32'(idxQ.size()), 1);
        if (idxQ.size() > 0) void'(idxQ.pop_front());
        @(negedge clk);
        checkOutput("idleAfterAbort", 32'(busy_o), 0);
`endif

        repeat (3) @(posedge clk);
        checkOutput("leftoverDone", 32'(doneQ.size()), 0);
        checkOutput("leftoverIters", 32'(idxQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
